// File: rtl/stage_wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: result-select encoding,
// load width codes and the IO window base addresses.
package stage_wb_pkg;

   // Writeback result source selector
   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   // Load width / sign codes carried in funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Upper address halves that route a load to the IO read bus
   localparam logic [15:0] IO_BASE0 = 16'h1000;
   localparam logic [15:0] IO_BASE1 = 16'h1001;

   // True when the address falls inside one of the two IO windows
   function automatic logic is_io_addr(input logic [31:0] addr);
      return (addr[31:16] == IO_BASE0) || (addr[31:16] == IO_BASE1);
   endfunction

endpackage

// File: rtl/stage_wb_load_fmt.sv
// Load formatter: picks the byte/half addressed by addr from a 32-bit word,
// sign- or zero-extends it according to funct3 and flags misaligned accesses.
// Purely combinational.
module load_fmt
   import stage_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane selection followed by width/sign extension
   always_comb begin
      byte_v = 8'h00;
      case (addr)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      // Half lane chosen by bit 1 only; bit 0 set is reported as misaligned
      half_v     = addr[1] ? word[31:16] : word[15:0];
      data       = 32'h0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_v[7]}}, byte_v};
         F3_LH:  begin
            data       = {{16{half_v[15]}}, half_v};
            misaligned = addr[0];
         end
         F3_LW:  begin
            data       = word;
            misaligned = |addr;
         end
         F3_LBU: data = {24'h0, byte_v};
         F3_LHU: begin
            data       = {16'h0, half_v};
            misaligned = addr[0];
         end
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/stage_wb.sv
// MEM/WB pipeline register and writeback stage. Captures the MEM-side
// instruction, selects the load source (IO or data memory), keeps the load
// word stable across stalls and drives the register-file write port.
// Optional build macro: WB_RETIRE_CNT_EN adds the o_retire_cnt counter.
module stage_wb
   import stage_wb_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_pc_plus4,
   input  logic [4:0]  i_rd_addr,
   input  logic        i_rd_wren,
   input  logic        i_mem_read,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_wb_sel,
   input  logic        i_ctrl_valid,
   input  logic        i_ctrl_kill,
   input  logic        i_ctrl_bubble,
   input  logic [31:0] i_dmem_rdata,
   input  logic [31:0] i_io_rdata,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_rd_wren,
   output logic        o_insn_vld,
   output logic        o_ld_misaligned
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0] o_retire_cnt
`endif
);

   logic        r_valid_q,       r_valid_d;
   logic [31:0] r_alu_result_q,  r_alu_result_d;
   logic [31:0] r_pc_plus4_q,    r_pc_plus4_d;
   logic [4:0]  r_rd_addr_q,     r_rd_addr_d;
   logic        r_rd_wren_q,     r_rd_wren_d;
   logic        r_mem_read_q,    r_mem_read_d;
   logic [2:0]  r_funct3_q,      r_funct3_d;
   wb_sel_e     r_wb_sel_q,      r_wb_sel_d;
   logic        r_is_io_q,       r_is_io_d;
   logic [31:0] hold_word_q,     hold_word_d;
   logic        hold_vld_q,      hold_vld_d;

   logic [31:0] live_word;
   logic [31:0] load_word;
   logic [31:0] load_data;
   logic        fmt_misaligned;
   logic        ld_misaligned;

   // Read data arrives in the WB cycle; source chosen by the captured address
   assign live_word = r_is_io_q ? i_io_rdata : i_dmem_rdata;
   // Once a stalled load has been latched, the memory bus may move on
   assign load_word = hold_vld_q ? hold_word_q : live_word;

   load_fmt u_load_fmt (
      .word       (load_word),
      .addr       (r_alu_result_q[1:0]),
      .funct3     (r_funct3_q),
      .data       (load_data),
      .misaligned (fmt_misaligned)
   );

   // Only loads can be misaligned; ALU ops reuse funct3 for other purposes
   assign ld_misaligned = r_mem_read_q & fmt_misaligned;

   // Next-state for the pipeline register and the stalled-load hold word
   always_comb begin
      r_valid_d      = r_valid_q;
      r_alu_result_d = r_alu_result_q;
      r_pc_plus4_d   = r_pc_plus4_q;
      r_rd_addr_d    = r_rd_addr_q;
      r_rd_wren_d    = r_rd_wren_q;
      r_mem_read_d   = r_mem_read_q;
      r_funct3_d     = r_funct3_q;
      r_wb_sel_d     = r_wb_sel_q;
      r_is_io_d      = r_is_io_q;
      hold_word_d    = hold_word_q;
      hold_vld_d     = hold_vld_q;

      if (!i_stall) begin
         r_valid_d      = i_ctrl_valid & ~i_ctrl_kill & ~i_ctrl_bubble;
         r_alu_result_d = i_alu_result;
         r_pc_plus4_d   = i_pc_plus4;
         r_rd_addr_d    = i_rd_addr;
         r_rd_wren_d    = i_rd_wren;
         r_mem_read_d   = i_mem_read;
         r_funct3_d     = i_funct3;
         r_wb_sel_d     = wb_sel_e'(i_wb_sel);
         r_is_io_d      = is_io_addr(i_alu_result);
      end
      // A flush turns whatever sits in WB into a bubble, even when stalled
      if (i_flush) begin
         r_valid_d = 1'b0;
      end

      // Capture the load word on the first stalled cycle only
      if (i_flush || !i_stall) begin
         hold_vld_d = 1'b0;
      end else if (!hold_vld_q && r_valid_q && r_mem_read_q) begin
         hold_vld_d  = 1'b1;
         hold_word_d = live_word;
      end
   end

   // Pipeline register state, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid_q      <= 1'b0;
         r_alu_result_q <= 32'h0;
         r_pc_plus4_q   <= 32'h0;
         r_rd_addr_q    <= 5'd0;
         r_rd_wren_q    <= 1'b0;
         r_mem_read_q   <= 1'b0;
         r_funct3_q     <= 3'd0;
         r_wb_sel_q     <= WB_SEL_ALU;
         r_is_io_q      <= 1'b0;
         hold_word_q    <= 32'h0;
         hold_vld_q     <= 1'b0;
      end else begin
         r_valid_q      <= r_valid_d;
         r_alu_result_q <= r_alu_result_d;
         r_pc_plus4_q   <= r_pc_plus4_d;
         r_rd_addr_q    <= r_rd_addr_d;
         r_rd_wren_q    <= r_rd_wren_d;
         r_mem_read_q   <= r_mem_read_d;
         r_funct3_q     <= r_funct3_d;
         r_wb_sel_q     <= r_wb_sel_d;
         r_is_io_q      <= r_is_io_d;
         hold_word_q    <= hold_word_d;
         hold_vld_q     <= hold_vld_d;
      end
   end

   // Writeback result mux; also feeds the forwarding network
   always_comb begin
      o_rd_data = 32'h0;
      case (r_wb_sel_q)
         WB_SEL_ALU:  o_rd_data = r_alu_result_q;
         WB_SEL_LOAD: o_rd_data = load_data;
         WB_SEL_PC4:  o_rd_data = r_pc_plus4_q;
         default:     o_rd_data = 32'h0;
      endcase
   end

   assign o_rd_addr       = r_rd_addr_q;
   // No write while stalled, so the instruction writes exactly once
   assign o_rd_wren       = r_valid_q & r_rd_wren_q & (r_rd_addr_q != 5'd0)
                            & ~ld_misaligned & ~i_stall;
   assign o_insn_vld      = r_valid_q & ~i_stall;
   assign o_ld_misaligned = r_valid_q & r_mem_read_q & fmt_misaligned;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q, retire_cnt_d;

   // Retired-instruction count, wraps naturally at 2^32
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (o_insn_vld) begin
         retire_cnt_d = retire_cnt_q + 32'd1;
      end
   end

   // Counter register, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         retire_cnt_q <= 32'h0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Testbench for stage_wb: directed cases with hand-computed values plus a
// randomized run checked every cycle against a behavioural model.
// Build with WB_RETIRE_CNT_EN defined to also exercise o_retire_cnt.
module tb_stage_wb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_stall, i_flush;
   logic [31:0] i_alu_result, i_pc_plus4;
   logic [4:0]  i_rd_addr;
   logic        i_rd_wren, i_mem_read;
   logic [2:0]  i_funct3;
   logic [1:0]  i_wb_sel;
   logic        i_ctrl_valid, i_ctrl_kill, i_ctrl_bubble;
   logic [31:0] i_dmem_rdata, i_io_rdata;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_rd_wren, o_insn_vld, o_ld_misaligned;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] o_retire_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   stage_wb dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_stall         (i_stall),
      .i_flush         (i_flush),
      .i_alu_result    (i_alu_result),
      .i_pc_plus4      (i_pc_plus4),
      .i_rd_addr       (i_rd_addr),
      .i_rd_wren       (i_rd_wren),
      .i_mem_read      (i_mem_read),
      .i_funct3        (i_funct3),
      .i_wb_sel        (i_wb_sel),
      .i_ctrl_valid    (i_ctrl_valid),
      .i_ctrl_kill     (i_ctrl_kill),
      .i_ctrl_bubble   (i_ctrl_bubble),
      .i_dmem_rdata    (i_dmem_rdata),
      .i_io_rdata      (i_io_rdata),
      .o_rd_addr       (o_rd_addr),
      .o_rd_data       (o_rd_data),
      .o_rd_wren       (o_rd_wren),
      .o_insn_vld      (o_insn_vld),
      .o_ld_misaligned (o_ld_misaligned)
`ifdef WB_RETIRE_CNT_EN
      ,
      .o_retire_cnt    (o_retire_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        rd_wren;
      logic        mem_read;
      logic [2:0]  f3;
      logic [1:0]  sel;
   } slot_t;

   slot_t       m_slot;
   logic        m_first;     // instruction is in its first WB cycle
   logic [31:0] m_word;      // memory word seen in that first cycle
   int          m_retired;

   function automatic logic [31:0] live_word(input logic [31:0] alu, input logic [31:0] io,
                                             input logic [31:0] dm);
      return (alu[31:16] == 16'h1000 || alu[31:16] == 16'h1001) ? io : dm;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd2:    return w;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic exp_mis(input logic [1:0] a, input logic [2:0] f3);
      if (f3 == 3'd1 || f3 == 3'd5) return a[0];
      if (f3 == 3'd2)               return a != 2'd0;
      return 1'b0;
   endfunction

   // The WB slot holds the most recently accepted instruction; a load uses the
   // memory word that was present during its first cycle in WB.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_slot  <= '0;
         m_first <= 1'b0;
         m_word  <= 32'h0;
      end else begin
         if (m_first) m_word <= live_word(m_slot.alu, i_io_rdata, i_dmem_rdata);
         m_first <= 1'b0;
         if (!i_stall) begin
            m_slot <= '{valid: i_ctrl_valid & ~i_ctrl_kill & ~i_ctrl_bubble,
                        alu: i_alu_result, pc4: i_pc_plus4, rd: i_rd_addr,
                        rd_wren: i_rd_wren, mem_read: i_mem_read, f3: i_funct3,
                        sel: i_wb_sel};
            m_first <= 1'b1;
         end
         if (i_flush) m_slot.valid <= 1'b0;
      end
   end

   // Per-cycle comparison against the model
   logic [31:0] c_word, c_data;
   logic        c_vld, c_mis, c_wren;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_wren", 32'(o_rd_wren), 32'h0);
         check("rst_vld",  32'(o_insn_vld), 32'h0);
         check("rst_mis",  32'(o_ld_misaligned), 32'h0);
         check("rst_data", o_rd_data, 32'h0);
         m_retired <= 0;
      end else begin
         c_word = m_first ? live_word(m_slot.alu, i_io_rdata, i_dmem_rdata) : m_word;
         c_vld  = m_slot.valid && !i_stall;
         c_mis  = m_slot.valid && m_slot.mem_read && exp_mis(m_slot.alu[1:0], m_slot.f3);
         c_wren = c_vld && m_slot.rd_wren && (m_slot.rd != 5'd0) &&
                  !(m_slot.mem_read && exp_mis(m_slot.alu[1:0], m_slot.f3));
         case (m_slot.sel)
            2'd0:    c_data = m_slot.alu;
            2'd1:    c_data = exp_load(c_word, m_slot.alu[1:0], m_slot.f3);
            2'd2:    c_data = m_slot.pc4;
            default: c_data = 32'h0;
         endcase
         check("cmp_vld",  32'(o_insn_vld), 32'(c_vld));
         check("cmp_wren", 32'(o_rd_wren), 32'(c_wren));
         check("cmp_mis",  32'(o_ld_misaligned), 32'(c_mis));
         if (c_vld) begin
            check("cmp_data", o_rd_data, c_data);
            check("cmp_rd",   32'(o_rd_addr), 32'(m_slot.rd));
            m_retired <= m_retired + 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      i_stall = 0; i_flush = 0; i_ctrl_valid = 0; i_ctrl_kill = 0; i_ctrl_bubble = 0;
      i_alu_result = 0; i_pc_plus4 = 0; i_rd_addr = 0; i_rd_wren = 0;
      i_mem_read = 0; i_funct3 = 0; i_wb_sel = 0;
   endtask

   task automatic issue(input logic [31:0] alu, input logic [4:0] rd, input logic memrd,
                        input logic [2:0] f3, input logic [1:0] sel);
      idle_in();
      i_ctrl_valid = 1; i_alu_result = alu; i_pc_plus4 = alu + 32'd4;
      i_rd_addr = rd; i_rd_wren = 1; i_mem_read = memrd; i_funct3 = f3; i_wb_sel = sel;
   endtask

   int vld_cnt, wr_cnt, sel_kind;

   initial begin
      idle_in();
      i_dmem_rdata = 0; i_io_rdata = 0;
      #1 rst_n = 0;
      repeat (2) @(negedge clk);
      check("reset_data", o_rd_data, 32'h0);
      check("reset_wren", 32'(o_rd_wren), 32'h0);
`ifdef WB_RETIRE_CNT_EN
      check("reset_cnt", o_retire_cnt, 32'h0);
`endif
      tick();
      rst_n = 1;
      tick();

      // LB from byte 3 of 0x80FF_1234
      issue(32'h0000_0003, 5'd7, 1, 3'b000, 2'b01);
      tick();
      idle_in(); i_dmem_rdata = 32'h80FF_1234; i_io_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      check("lb_data", o_rd_data, 32'hFFFF_FF80);
      check("lb_wren", 32'(o_rd_wren), 32'h1);
      tick();

      // LHU from the IO window, upper half
      issue(32'h1000_0002, 5'd8, 1, 3'b101, 2'b01);
      tick();
      idle_in(); i_io_rdata = 32'hBEEF_0001; i_dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("lhu_io_data", o_rd_data, 32'h0000_BEEF);
      check("lhu_io_wren", 32'(o_rd_wren), 32'h1);
      tick();

      // Misaligned LW
      issue(32'h0000_0006, 5'd5, 1, 3'b010, 2'b01);
      tick();
      idle_in(); i_dmem_rdata = $urandom;
      @(negedge clk);
      check("lw_mis_flag", 32'(o_ld_misaligned), 32'h1);
      check("lw_mis_wren", 32'(o_rd_wren), 32'h0);
      tick();

      // Load held across three stall cycles while memory data changes
      issue(32'h0000_0100, 5'd3, 1, 3'b010, 2'b01);
      tick();
      idle_in(); i_stall = 1; i_dmem_rdata = 32'hCAFE_F00D;
      vld_cnt = 0; wr_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vld_cnt += int'(o_insn_vld);
         wr_cnt  += int'(o_rd_wren);
         if (k == 3) check("hold_data", o_rd_data, 32'hCAFE_F00D);
         tick();
         i_dmem_rdata = 32'hDEAD_DEAD;
         if (k == 2) i_stall = 0;
      end
      @(negedge clk);
      vld_cnt += int'(o_insn_vld);
      wr_cnt  += int'(o_rd_wren);
      check("hold_vld_once",  32'(vld_cnt), 32'd1);
      check("hold_wren_once", 32'(wr_cnt), 32'd1);
      tick();

      // Stall together with flush drops the instruction
      issue(32'h0000_0055, 5'd9, 0, 3'b000, 2'b00);
      tick();
      idle_in(); i_stall = 1; i_flush = 1;
      @(negedge clk);
      check("stfl_vld_now", 32'(o_insn_vld), 32'h0);
      tick();
      idle_in();
      @(negedge clk);
      check("stfl_wren_next", 32'(o_rd_wren), 32'h0);
      check("stfl_vld_next",  32'(o_insn_vld), 32'h0);
      tick();

      // Write to x0 retires without a register write
      issue(32'h0000_0077, 5'd0, 0, 3'b000, 2'b00);
      tick();
      idle_in();
      @(negedge clk);
      check("x0_vld",  32'(o_insn_vld), 32'h1);
      check("x0_wren", 32'(o_rd_wren), 32'h0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle_in();
         sel_kind = int'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       i_alu_result = {16'h1000, 16'($urandom)};
            1:       i_alu_result = {16'h1001, 16'($urandom)};
            2:       i_alu_result = {16'h1002, 16'($urandom)};
            default: i_alu_result = $urandom;
         endcase
         i_pc_plus4    = $urandom;
         i_rd_addr     = 5'($urandom);
         i_rd_wren     = ($urandom_range(0, 4) != 0);
         i_funct3      = 3'($urandom);
         i_wb_sel      = 2'(sel_kind);
         i_mem_read    = (sel_kind == 1);
         i_ctrl_valid  = ($urandom_range(0, 9) != 0);
         i_ctrl_kill   = ($urandom_range(0, 9) == 0);
         i_ctrl_bubble = ($urandom_range(0, 9) == 0);
         i_stall       = ($urandom_range(0, 3) == 0);
         i_flush       = ($urandom_range(0, 19) == 0);
         i_dmem_rdata  = $urandom;
         i_io_rdata    = $urandom;
         tick();
      end
      idle_in();
      repeat (2) tick();
      @(negedge clk);
      #1;
`ifdef WB_RETIRE_CNT_EN
      check("cnt_vs_retired", o_retire_cnt, 32'(m_retired));
`endif
      tick();

      // Reset in the middle of a load: outputs clear without waiting for a clock
      issue(32'h0000_0200, 5'd4, 1, 3'b010, 2'b01);
      tick();
      idle_in(); i_dmem_rdata = 32'h1111_2222;
      #2 rst_n = 0;
      #1;
      check("midrst_wren", 32'(o_rd_wren), 32'h0);
      check("midrst_vld",  32'(o_insn_vld), 32'h0);
      check("midrst_data", o_rd_data, 32'h0);
      check("midrst_addr", 32'(o_rd_addr), 32'h0);
`ifdef WB_RETIRE_CNT_EN
      check("midrst_cnt", o_retire_cnt, 32'h0);
`endif
      tick();
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("postrst_wren", 32'(o_rd_wren), 32'h0);
         tick();
      end

`ifdef WB_RETIRE_CNT_EN
      // Counter wraps from all-ones to zero on one retire
      issue(32'h0000_0001, 5'd2, 0, 3'b000, 2'b00);
      @(negedge clk);
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.retire_cnt_q;
      tick();
      idle_in();
      @(negedge clk);
      check("wrap_pre_cnt", o_retire_cnt, 32'hFFFF_FFFF);
      check("wrap_pre_vld", 32'(o_insn_vld), 32'h1);
      tick();
      @(negedge clk);
      check("wrap_cnt", o_retire_cnt, 32'h0);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stage_wb.md
STAGE_WB -- requirements
Module: stage_wb

Interface
REQ-001 SHALL have i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have i_reset_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have i_stall, input, 1, hold the MEM/WB register.
REQ-004 SHALL have i_flush, input, 1, replace the captured instruction with a bubble.
REQ-005 SHALL have i_alu_result, input, 32, memory address or ALU result from the MEM side.
REQ-006 SHALL have i_pc_plus4, input, 32, link value for JAL/JALR.
REQ-007 SHALL have i_rd_addr, input, 5, and i_rd_wren, input, 1, destination register and its write request.
REQ-008 SHALL have i_mem_read, input, 1, and i_funct3, input, 3, load flag and load width/sign code.
REQ-009 SHALL have i_wb_sel, input, 2, where 00 is ALU, 01 is load, 10 is PC+4, and 11 is reserved and yields 0.
REQ-010 SHALL have i_ctrl_valid, i_ctrl_kill and i_ctrl_bubble, input, 1 each, instruction qualifiers.
REQ-011 SHALL have i_dmem_rdata and i_io_rdata, input, 32 each, read data arriving one cycle after the address.
REQ-012 SHALL have o_rd_addr, output, 5, o_rd_data, output, 32, and o_rd_wren, output, 1, the register-file write port, also used for forwarding.
REQ-013 SHALL have o_insn_vld, output, 1, retiring instruction; and o_ld_misaligned, output, 1, misaligned-load flag.

Function
REQ-014 SHALL capture all MEM-side inputs except the rdata buses into r_* registers on each edge where i_stall=0.
REQ-015 SHALL set r_valid = i_ctrl_valid & ~i_ctrl_kill & ~i_ctrl_bubble on capture.
REQ-016 SHALL clear r_valid on i_flush; flush overrides stall in the same cycle.
REQ-017 SHALL hold all r_* registers unchanged while i_stall=1 and i_flush=0.
REQ-018 SHALL register r_is_io=1 when i_alu_result[31:16] is 0x1000 or 0x1001; load source is i_io_rdata if r_is_io, else i_dmem_rdata.
REQ-019 SHALL latch the selected load word into a hold register on the first stall cycle in which r_valid & r_mem_read, and use the held word while the stall persists; live data is used otherwise.
REQ-020 SHALL format loads from r_alu_result[1:0]: LB 000 sign-extends a byte; LH 001 sign-extends a half selected by bit 1; LW 010 passes the word; LBU 100 and LHU 101 zero-extend; other codes yield 0.
REQ-021 SHALL flag a load as misaligned when LH/LHU has addr[0]=1 or LW has addr[1:0]≠0.
REQ-022 SHALL drive o_ld_misaligned = r_valid & r_mem_read & misaligned, and force o_rd_wren=0 for that instruction.
REQ-023 SHALL drive o_rd_wren = r_valid & r_rd_wren & (r_rd_addr≠0) & ~misaligned, and 0 while i_stall=1.
REQ-024 SHALL make o_rd_data a combinational function of r_* and rdata; latency is one edge from MEM inputs to the WB outputs.
REQ-025 SHALL drive o_insn_vld = r_valid & ~i_stall, so a stalled instruction retires exactly once.

Reset
REQ-026 SHALL on i_reset_n=0 asynchronously clear all r_*, the hold register and the hold flag; all outputs read 0 during reset.
REQ-027 SHALL drop any in-flight instruction on reset mid-operation, with no write after deassertion until a new capture.

Configuration
REQ-028 SHALL, when WB_RETIRE_CNT_EN is defined, add o_retire_cnt, output, 32, incremented on each o_insn_vld, wrapping 0xFFFFFFFF to 0, and reset to 0.
REQ-029 SHALL, without WB_RETIRE_CNT_EN, have neither the port nor the counter.

Structure
REQ-030 SHALL take the wb_sel encoding enum, load funct3 constants and the IO base addresses (0x1000, 0x1001) from the shared package.
REQ-031 SHALL place the byte/half extraction and extension in the combinational sub-module load_fmt (inputs word, addr[1:0], funct3; outputs data, misaligned).

Verification
REQ-032 SHALL cover: LB at addr 0x...3 with dmem word 0x80FF_1234 -> o_rd_data=0xFFFF_FF80, o_rd_wren=1.
REQ-033 SHALL cover: LHU at 0x1000_0002 with io word 0xBEEF_0001 -> o_rd_data=0x0000_BEEF.
REQ-034 SHALL cover: LW at addr 0x6, rd=5 -> o_ld_misaligned=1, o_rd_wren=0.
REQ-035 SHALL cover: a load, then 3 stall cycles while dmem rdata changes to 0xDEAD_DEAD -> original word written once, o_insn_vld pulses once.
REQ-036 SHALL cover: stall and flush together -> next cycle o_rd_wren=0, o_insn_vld=0; a write to rd=0 -> o_rd_wren=0.
REQ-037 SHALL cover: i_reset_n asserted mid-load -> outputs 0 immediately; with WB_RETIRE_CNT_EN, o_retire_cnt=0 and preset 0xFFFFFFFF plus one retire -> 0.
